csa_prod_accum: RTL and testbench

- Downstream consumer of the 4x4 carry-save multiplier's 8-bit product stream.
- Registers each accepted product and sums N_TERMS consecutive products into one frame result, e.g. a dot-product or FIR tap sum.
- Presents the frame result on a valid/ready output handshake and holds it until it is taken.
- Pure control and accumulation; the multiplier stays combinational upstream.

---
 rtl/csa_prod_accum.sv | 96 +++++++++
 tb/tb_csa_prod_accum.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_prod_accum.sv
// Accumulates N_TERMS consecutive 8-bit products into one frame sum and
// offers it on a valid/ready port, holding it until downstream takes it.
module csa_prod_accum #(
  parameter int N_TERMS = 16,
  parameter int ACC_W   = 12,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       p,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [CNT_W-1:0] term_cnt,
  output logic             ovf,
  output logic             state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both 1. Input side: p_valid/p_ready. Output side: sum_valid/sum_ready;
  // sum_valid stays 1 and sum/ovf stay frozen until that transfer occurs.

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] sum_q;
  logic             sum_valid_q;
  logic             ovf_q;

  logic [ACC_W:0]   add_d;
  logic             accept_d;
  logic             last_d;

  // One extra bit on the adder keeps the modulo-2^ACC_W carry for ovf.
  assign add_d    = {1'b0, acc_q} + (ACC_W + 1)'(p);
  assign p_ready  = (state_q == ACCUM) & ~clear & ~rst;
  assign accept_d = p_valid & p_ready;
  assign last_d   = (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end else if (accept_d) begin
            if (last_d) begin
              sum_q       <= add_d[ACC_W-1:0];
              sum_valid_q <= 1'b1;
              ovf_q       <= ovf_q | add_d[ACC_W];
              acc_q       <= '0;
              cnt_q       <= '0;
              state_q     <= HOLD;
            end else begin
              acc_q <= add_d[ACC_W-1:0];
              cnt_q <= cnt_q + CNT_W'(1);
              ovf_q <= ovf_q | add_d[ACC_W];
            end
          end
        end
        HOLD: begin
          // clear is deliberately ignored here so a finished result is never lost.
          if (sum_valid_q & sum_ready) begin
            sum_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign term_cnt  = cnt_q;
  assign ovf       = ovf_q;
  assign state_dbg = (state_q == HOLD);

endmodule

// File: tb/tb_csa_prod_accum.sv
// Bench for csa_prod_accum: frame table plus hand sequences for clear,
// reset and overflow, with a queue scoreboard on the sum handshake.
module tb_csa_prod_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  p;
  logic        p_valid;
  logic        p_ready;
  logic        clear;
  logic [11:0] sum;
  logic        sum_valid;
  logic        sum_ready;
  logic [7:0]  term_cnt;
  logic        ovf;
  logic        state_dbg;

  logic [7:0]  p2;
  logic        p2_valid;
  logic        p2_ready;
  logic        clear2;
  logic [7:0]  sum2;
  logic        sum2_valid;
  logic        sum2_ready;
  logic [1:0]  term_cnt2;
  logic        ovf2;
  logic        state2_dbg;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  typedef struct {
    logic [7:0]  val;
    bit          gapped;
    int          hold;
    bit          pre_clear;
    logic [11:0] exp_sum;
    int          exp_stall;
  } row_t;

  row_t rows[7];

  csa_prod_accum #(.N_TERMS(16), .ACC_W(12), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .p(p), .p_valid(p_valid), .p_ready(p_ready),
    .clear(clear), .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .term_cnt(term_cnt), .ovf(ovf), .state_dbg(state_dbg)
  );

  csa_prod_accum #(.N_TERMS(4), .ACC_W(8), .CNT_W(2)) dut_ovf (
    .clk(clk), .rst(rst), .p(p2), .p_valid(p2_valid), .p_ready(p2_ready),
    .clear(clear2), .sum(sum2), .sum_valid(sum2_valid), .sum_ready(sum2_ready),
    .term_cnt(term_cnt2), .ovf(ovf2), .state_dbg(state2_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: a result transfers on the edge after a negedge with valid & ready
  always @(negedge clk) begin
    if (!rst && sum_valid && sum_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_sum", {19'd0, ovf, sum}, 32'h1FFF);
      end else begin
        chk("sb_sum_ovf", {19'd0, ovf, sum}, {19'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_n(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      p = v;
      p_valid = 1'b1;
      #1;
      chk("push_ready", p_ready, 1);
      cycle();
    end
    p_valid = 1'b0;
  endtask

  task automatic feed(input row_t r);
    int  acc_n = 0;
    int  cyc = 0;
    int  stall = 0;
    bit  acc;
    sum_ready = 1'b1;
    while (acc_n < 16 && cyc < 200) begin
      p = r.val;
      p_valid = r.gapped ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk("term_cnt_run", term_cnt, acc_n);
      acc = p_valid & p_ready;
      if (p_valid && !p_ready) stall++;
      if (acc && acc_n == 15) exp_q.push_back({1'b0, r.exp_sum});
      cycle();
      if (acc) acc_n++;
      cyc++;
    end
    p_valid = 1'b0;
    if (r.hold > 0) sum_ready = 1'b0;
    chk("frame_accepts", acc_n, 16);
    chk("stall_cycles", stall, r.exp_stall);
    chk("sum_valid_latency", sum_valid, 1);
    chk("term_cnt_wrap", term_cnt, 0);
    chk("ovf_frame", ovf, 0);
    if (r.hold > 0) begin
      for (int h = 0; h < r.hold; h++) begin
        clear = 1'b1;
        p = 8'd7;
        p_valid = 1'b1;
        #1;
        chk("hold_p_ready", p_ready, 0);
        cycle();
        chk("hold_sum", sum, r.exp_sum);
        chk("hold_sum_valid", sum_valid, 1);
      end
      clear = 1'b0;
      p_valid = 1'b0;
      sum_ready = 1'b1;
      cycle();
      chk("release_sum_valid", sum_valid, 0);
    end
  endtask

  initial begin
    logic [7:0] ov_vals[4];
    ov_vals = '{8'd200, 8'd100, 8'd50, 8'd10};

    //        val     gap   hold pre   exp_sum   stall
    rows[0] = '{8'd225, 1'b0, 5, 1'b0, 12'd3600, 0};
    rows[1] = '{8'd1,   1'b0, 0, 1'b0, 12'd16,   0};
    rows[2] = '{8'd1,   1'b0, 0, 1'b0, 12'd16,   1};
    rows[3] = '{8'd3,   1'b1, 2, 1'b0, 12'd48,   1};
    rows[4] = '{8'd2,   1'b0, 3, 1'b1, 12'd32,   0};
    rows[5] = '{8'd200, 1'b0, 2, 1'b0, 12'd3200, 0};
    rows[6] = '{8'd0,   1'b1, 1, 1'b0, 12'd0,    0};

    rst = 1'b1; p = '0; p_valid = 1'b0; clear = 1'b0; sum_ready = 1'b0;
    p2 = '0; p2_valid = 1'b0; clear2 = 1'b0; sum2_ready = 1'b0;
    #1;
    chk("reset_p_ready", p_ready, 0);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("reset_sum", sum, 0);
    chk("reset_sum_valid", sum_valid, 0);
    chk("reset_term_cnt", term_cnt, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_state", state_dbg, 0);
    chk("post_reset_p_ready", p_ready, 1);

    for (int r = 0; r < 7; r++) begin
      if (rows[r].pre_clear) begin
        push_n(8'd100, 5);
        chk("pre_clear_cnt", term_cnt, 5);
        clear = 1'b1;
        p = 8'd7;
        p_valid = 1'b1;
        #1;
        chk("clear_p_ready", p_ready, 0);
        cycle();
        chk("clear_term_cnt", term_cnt, 0);
        clear = 1'b0;
        p_valid = 1'b0;
      end
      feed(rows[r]);
    end

    // reset while holding a result
    sum_ready = 1'b0;
    push_n(8'd4, 16);
    chk("hold_before_rst_valid", sum_valid, 1);
    chk("hold_before_rst_sum", sum, 64);
    chk("hold_before_rst_state", state_dbg, 1);
    rst = 1'b1;
    #1;
    chk("rst_hold_p_ready", p_ready, 0);
    cycle();
    rst = 1'b0;
    chk("rst_hold_sum_valid", sum_valid, 0);
    chk("rst_hold_sum", sum, 0);
    chk("rst_hold_state", state_dbg, 0);

    // reset mid-frame
    push_n(8'd5, 9);
    chk("mid_term_cnt", term_cnt, 9);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_term_cnt", term_cnt, 0);
    chk("rst_mid_sum_valid", sum_valid, 0);
    chk("rst_mid_ovf", ovf, 0);
    exp_q.push_back({1'b0, 12'd16});
    sum_ready = 1'b1;
    push_n(8'd1, 16);
    cycle();
    chk("post_rst_frame_taken", sum_valid, 0);
    sum_ready = 1'b0;

    // overflow on the narrow instance
    for (int i = 0; i < 4; i++) begin
      p2 = ov_vals[i];
      p2_valid = 1'b1;
      #1;
      chk("ovf_p2_ready", p2_ready, 1);
      cycle();
      if (i == 1) chk("ovf_sticky_mid", ovf2, 1);
    end
    p2_valid = 1'b0;
    chk("ovf_sum", sum2, 104);
    chk("ovf_flag", ovf2, 1);
    chk("ovf_sum_valid", sum2_valid, 1);
    sum2_ready = 1'b1;
    cycle();
    sum2_ready = 1'b0;
    chk("ovf_taken_valid", sum2_valid, 0);
    chk("ovf_taken_flag", ovf2, 0);
    for (int i = 0; i < 4; i++) begin
      p2 = 8'd1;
      p2_valid = 1'b1;
      cycle();
    end
    p2_valid = 1'b0;
    chk("ovf_next_sum", sum2, 4);
    chk("ovf_next_flag", ovf2, 0);
    chk("ovf_next_valid", sum2_valid, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
